// File: rtl/comparador_der_izq.sv
// Bit-serial unsigned magnitude comparator, scanning LSB first, one bit per clock.
// The most significant differing bit is seen last, so it always decides the result.
module comparador_der_izq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] wordA,
    input  logic [N-1:0] wordB,
    output logic         busy,
    output logic         valid,
    output logic         a_gt_b,
    output logic         a_eq_b,
    output logic         a_lt_b
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
    typedef enum logic [1:0] {REL_EQ = 2'b00, REL_GT = 2'b01, REL_LT = 2'b10} rel_t;

    state_t        state_q, state_d;
    logic [N-1:0]  sha_q, sha_d, shb_q, shb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    rel_t          rel_q, rel_d, rel_step;
    logic [2:0]    res_q, res_d;   // {gt, eq, lt}
    logic          accept, last_bit;

    assign accept   = start && (state_q != S_SHIFT);
    assign last_bit = (cnt_q == CW'(N - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_SHIFT;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy   = (state_q == S_SHIFT);
        valid  = (state_q == S_DONE);
        a_gt_b = res_q[2];
        a_eq_b = res_q[1];
        a_lt_b = res_q[0];
    end

    // Relation after folding in the current LSB pair
    always_comb begin
        rel_step = rel_q;
        if (sha_q[0] && !shb_q[0])      rel_step = REL_GT;
        else if (!sha_q[0] && shb_q[0]) rel_step = REL_LT;
    end

    // Datapath
    always_comb begin
        sha_d = sha_q;
        shb_d = shb_q;
        cnt_d = cnt_q;
        rel_d = rel_q;
        res_d = res_q;
        if (state_q == S_SHIFT) begin
            sha_d = sha_q >> 1;
            shb_d = shb_q >> 1;
            cnt_d = cnt_q + CW'(1);
            rel_d = rel_step;
            if (last_bit) begin
                case (rel_step)
                    REL_GT:  res_d = 3'b100;
                    REL_LT:  res_d = 3'b001;
                    default: res_d = 3'b010;
                endcase
            end
        end else if (accept) begin
            sha_d = wordA;
            shb_d = wordB;
            cnt_d = '0;
            rel_d = REL_EQ;
            res_d = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sha_q <= '0;
            shb_q <= '0;
            cnt_q <= '0;
            rel_q <= REL_EQ;
            res_q <= 3'b000;
        end else begin
            sha_q <= sha_d;
            shb_q <= shb_d;
            cnt_q <= cnt_d;
            rel_q <= rel_d;
            res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_comparador_der_izq.sv
// Directed bench: an N=8 comparator driven from a vector table plus corner sequences,
// and an N=1 instance for the single-bit case.
module tb_comparador_der_izq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, start1;
    logic [7:0] wa8, wb8;
    logic [0:0] wa1, wb1;
    logic       busy8, valid8, gt8, eq8, lt8;
    logic       busy1, valid1, gt1, eq1, lt1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    comparador_der_izq #(.N(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .wordA(wa8), .wordB(wb8),
        .busy(busy8), .valid(valid8), .a_gt_b(gt8), .a_eq_b(eq8), .a_lt_b(lt8)
    );

    comparador_der_izq #(.N(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .wordA(wa1), .wordB(wb1),
        .busy(busy1), .valid(valid1), .a_gt_b(gt1), .a_eq_b(eq1), .a_lt_b(lt1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       gt;
        logic       eq;
        logic       lt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // Status word {busy, valid, gt, eq, lt}
    function automatic logic [7:0] st8();
        return {3'b000, busy8, valid8, gt8, eq8, lt8};
    endfunction

    function automatic logic [7:0] st1();
        return {3'b000, busy1, valid1, gt1, eq1, lt1};
    endfunction

    // Start is presented at a negedge and accepted on the following posedge (edge k);
    // returns at the negedge after edge k.
    task automatic start_op8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start8 = 1'b1; wa8 = a; wb8 = b;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h01, 8'h02, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h7F, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'hFE, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0};

        start8 = 1'b0; start1 = 1'b0;
        wa8 = '0; wb8 = '0; wa1 = '0; wb1 = '0;
        reset = 1'b1;
        #1;
        chk("reset8", st8(), 8'h00);
        chk("reset1", st1(), 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Table: each op after the first is issued from DONE, so valid/results must clear
        for (int i = 0; i < 10; i++) begin
            start_op8(vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_edge_k", i), st8(), 8'h10);
            repeat (7) @(negedge clk);
            chk($sformatf("v%0d_edge_k+7", i), st8(), 8'h10);
            @(negedge clk);
            chk($sformatf("v%0d_result", i), st8(),
                {3'b000, 1'b0, 1'b1, vecs[i].gt, vecs[i].eq, vecs[i].lt});
        end

        // Result holds in DONE while start stays low
        repeat (6) @(negedge clk);
        chk("done_hold", st8(), {3'b000, 1'b0, 1'b1, vecs[9].gt, vecs[9].eq, vecs[9].lt});

        // A start and operand changes during SHIFT are ignored
        start_op8(8'h10, 8'h20);
        repeat (2) @(negedge clk);
        start8 = 1'b1; wa8 = 8'hFF; wb8 = 8'h00;
        @(negedge clk);
        start8 = 1'b0; wa8 = 8'h55; wb8 = 8'h11;
        chk("ignore_busy_e3", st8(), 8'h10);
        repeat (4) @(negedge clk);
        chk("ignore_busy_e7", st8(), 8'h10);
        @(negedge clk);
        chk("ignore_result", st8(), 8'h09);

        // Asynchronous reset mid-SHIFT, between edges 4 and 5
        start_op8(8'hF0, 8'h0F);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_shift", st8(), 8'h00);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stays_idle", st8(), 8'h00);
        start_op8(8'hF0, 8'h0F);
        repeat (8) @(negedge clk);
        chk("after_rst_result", st8(), 8'h0C);

        // Asynchronous reset while holding a result in DONE
        #2 reset = 1'b1;
        #1;
        chk("async_rst_done", st8(), 8'h00);
        #1 reset = 1'b0;

        // N=1: result one edge after acceptance, back-to-back from DONE
        for (int j = 0; j < 3; j++) begin
            logic [7:0] exp1;
            @(negedge clk);
            start1 = 1'b1;
            wa1 = (j == 0) ? 1'b1 : 1'b0;
            wb1 = (j == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("n1_%0d_busy", j), st1(), 8'h10);
            @(negedge clk);
            exp1 = (j == 0) ? 8'h0C : (j == 1) ? 8'h0A : 8'h09;
            chk($sformatf("n1_%0d_result", j), st1(), exp1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/comparador_der_izq.md
Name: comparador_der_izq

Overview:
- Sequential serial magnitude comparator that traverses operands right-to-left: LSB first, one bit per clock.
- Complements the combinational left-to-right comparator in the same project.
- Each operand pair is captured on a start pulse and scanned over N cycles. The registered GT/EQ/LT result is then held with a valid flag until the next operation.
- Feeds downstream control logic that needs a low-area, bit-serial compare.

Parameters:
- N, 8, operand width in bits; legal range N >= 1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; sampled on rising edge; honoured only in IDLE or DONE.
- wordA  input  N  operand A; sampled only on an accepted start.
- wordB  input  N  operand B; sampled only on an accepted start.
- busy  output  1  high while the scan is in progress (state SHIFT).
- valid  output  1  high while the result outputs hold a completed comparison (state DONE).
- a_gt_b  output  1  A > B (unsigned); meaningful only when valid=1.
- a_eq_b  output  1  A == B; meaningful only when valid=1.
- a_lt_b  output  1  A < B (unsigned); meaningful only when valid=1.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; shift registers and counter cleared; relation=EQ.
  - busy=0, valid=0, a_gt_b=0, a_eq_b=0, a_lt_b=0.
  - Takes effect immediately, without a clock edge.
- Internal state:
  - shA, shB: N-bit shift registers.
  - cnt: counter of width clog2(N+1).
  - rel: 2-bit relation code, EQ/GT/LT.
  - FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: shA<=wordA, shB<=wordB, cnt<=0, rel<=EQ, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, per edge:
  - Compare shA[0] with shB[0]. If a=1,b=0 then rel<=GT; if a=0,b=1 then rel<=LT; if equal, rel is unchanged.
  - A later (more significant) differing bit always overrides an earlier one.
  - Shift shA and shB right by 1 (zero fill); cnt<=cnt+1.
  - When the edge processes cnt==N-1: go to DONE and load the result outputs from the updated rel. Exactly one of a_gt_b/a_eq_b/a_lt_b is 1.
  - start is ignored in SHIFT; wordA/wordB changes have no effect.
- DONE:
  - valid=1; result outputs held stable.
  - start=1 at an edge: capture new operands and go to SHIFT exactly as from IDLE. On that same edge, valid and the result outputs clear to 0.
  - start=0: remain in DONE indefinitely.
- Outputs:
  - busy and valid are decoded from registered state; never both 1.
  - Result outputs are registered and are 0 whenever valid=0.
  - Intermediate rel is never exposed.
- Latency:
  - Start accepted at edge k gives busy=1 after edge k.
  - valid=1 and results stable after edge k+N.
  - Throughput is one compare per N+1 cycles (start re-issued in DONE).
- N=1: one SHIFT edge; valid after edge k+1.
- Reset mid-SHIFT or mid-DONE aborts the operation. Outputs return to reset values and no partial result is ever presented.
- Counter never wraps; cnt stops at N in DONE and is reloaded on the next start.

Test Plan:
- N=8, A=0xA5, B=0xA5, start at edge 0 → busy=1 over edges 1-7; after edge 8 valid=1, a_eq_b=1, a_gt_b=0, a_lt_b=0.
- N=8, A=0x80, B=0x7F → after 8 scan edges a_gt_b=1. The MSB overrides the earlier LT decisions from bits 0-6.
- N=8, A=0x01, B=0x02 → a_lt_b=1. Then start in DONE with A=0xFF, B=0x00: valid drops on that edge, and a_gt_b=1 after 8 more edges.
- N=8, A=0x10, B=0x20 start; at edge 3 assert start with A=0xFF, B=0x00 and change wordA/wordB → second start ignored; final result a_lt_b=1 at edge 8.
- Start with A=0xF0, B=0x0F; assert reset asynchronously mid-cycle between edges 4 and 5 → busy, valid and all results go to 0 immediately, without a clock edge; state IDLE; new start afterwards completes normally.
- N=1: A=1, B=0 → valid with a_gt_b=1 after edge 1. Then A=0, B=0 → a_eq_b=1. Then A=0, B=1 → a_lt_b=1.
